board_input_ctrl: RTL

- Hardware-side source for the operator path: turns raw board inputs (16 slide switches, 5 push buttons) into the clean SW word and SELECTOR mode consumed by select_action.
- Provides the inputs the file-driven emulator bench otherwise injects.
- Synchronizes and debounces all inputs, generates single-cycle button press pulses, and runs a mode-select state machine plus a switch-hold latch.

---
 rtl/board_input_ctrl.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/board_input_ctrl.sv
// board_input_ctrl: operator-path front end for select_action.
// Turns raw slide switches and push buttons into a clean SW word, a
// SELECTOR operation mode, a HOLD (switch freeze) flag and one-cycle
// button press pulses {C,U,D,L,R}.
//
// Optional feature: define BOARD_INPUT_AUTO_REPEAT_EN to make a held
// U or D button auto-step the mode (first step after 4*REPEAT_CYCLES,
// then every REPEAT_CYCLES). Without it, one press gives one step.

module board_input_ctrl #(
   parameter int BITS            = 16,
   parameter int NUM_MODES       = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 64,
   localparam int MW             = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] SW_RAW,
   input  logic            BTNC_RAW,
   input  logic            BTNU_RAW,
   input  logic            BTND_RAW,
   input  logic            BTNL_RAW,
   input  logic            BTNR_RAW,
   output logic [BITS-1:0] SW,
   output logic [MW-1:0]   SELECTOR,
   output logic            HOLD,
   output logic [4:0]      BTN_PULSE
);

   // Button bit positions inside the 5-bit button vectors.
   localparam int B_C = 4;
   localparam int B_U = 3;
   localparam int B_D = 2;
   localparam int B_L = 1;
   localparam int B_R = 0;

   localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);

   typedef logic [MW-1:0] opr_mode_t;
   localparam opr_mode_t MODE_ADD  = '0;
   localparam opr_mode_t MODE_LAST = opr_mode_t'(NUM_MODES - 1);

   typedef enum logic {
      HOLD_OFF = 1'b0,
      HOLD_ON  = 1'b1
   } hold_state_t;

   logic [4:0] btn_raw;
   assign btn_raw = {BTNC_RAW, BTNU_RAW, BTND_RAW, BTNL_RAW, BTNR_RAW};

   // ------------------------------------------------------------------
   // Two-flop synchronizers for switches and buttons
   // ------------------------------------------------------------------
   logic [BITS-1:0] sw_s1_q, sw_s1_d, sw_sync_q, sw_sync_d;
   logic [4:0]      btn_s1_q, btn_s1_d, btn_sync_q, btn_sync_d;

   // Next values of the synchronizer chains
   always_comb begin
      sw_s1_d    = SW_RAW;
      sw_sync_d  = sw_s1_q;
      btn_s1_d   = btn_raw;
      btn_sync_d = btn_s1_q;
   end

   // Synchronizer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s1_q    <= '0;
         sw_sync_q  <= '0;
         btn_s1_q   <= '0;
         btn_sync_q <= '0;
      end else begin
         sw_s1_q    <= sw_s1_d;
         sw_sync_q  <= sw_sync_d;
         btn_s1_q   <= btn_s1_d;
         btn_sync_q <= btn_sync_d;
      end
   end

   // ------------------------------------------------------------------
   // Post-reset settle: the synchronizers hold reset zeros for two
   // cycles, so a "released" observation is only trusted afterwards.
   // ------------------------------------------------------------------
   logic [1:0] settle_q, settle_d;
   logic       settled;

   assign settled = (settle_q == 2'd2);

   // Count up to 2 after reset and stay there
   always_comb begin
      settle_d = settle_q;
      if (!settled) begin
         settle_d = settle_q + 1'b1;
      end
   end

   // Settle counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_q <= '0;
      end else begin
         settle_q <= settle_d;
      end
   end

   // ------------------------------------------------------------------
   // Per-button debounce, arming and rising-edge pulse
   // ------------------------------------------------------------------
   logic [4:0] db_vec;
   logic [4:0] pulse_vec;

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_btn
         logic [DBW-1:0] cnt_q, cnt_d;
         logic           db_q, db_d;
         logic           armed_q, armed_d;
         logic           pulse_q, pulse_d;

         // Debounce: the level only moves after DEBOUNCE_CYCLES
         // consecutive disagreeing samples. A button held through
         // reset stays unarmed until it has been seen released, so
         // that press never produces a pulse.
         always_comb begin
            cnt_d   = '0;
            db_d    = db_q;
            armed_d = armed_q | (settled & ~btn_sync_q[gi]);
            if (btn_sync_q[gi] != db_q) begin
               if (cnt_q == DB_MAX) begin
                  db_d  = btn_sync_q[gi];
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            pulse_d = db_d & ~db_q & armed_q;
         end

         // Debounce state registers
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q   <= '0;
               db_q    <= 1'b0;
               armed_q <= 1'b0;
               pulse_q <= 1'b0;
            end else begin
               cnt_q   <= cnt_d;
               db_q    <= db_d;
               armed_q <= armed_d;
               pulse_q <= pulse_d;
            end
         end

         assign db_vec[gi]    = db_q;
         assign pulse_vec[gi] = pulse_q;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Auto-repeat for held U / D
   // ------------------------------------------------------------------
   logic rep_up;
   logic rep_dn;

`ifdef BOARD_INPUT_AUTO_REPEAT_EN
   localparam int RPW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RPW-1:0] RP_MAX = RPW'(REPEAT_CYCLES - 1);

   logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
   logic [1:0]     rep_phase_q, rep_phase_d;
   logic           rep_active;
   logic           rep_fire;

   // Exactly one of U/D held keeps the repeat timer running
   assign rep_active = db_vec[B_U] ^ db_vec[B_D];

   // Three silent periods, then a step at the end of every period
   always_comb begin
      rep_cnt_d   = '0;
      rep_phase_d = '0;
      rep_fire    = 1'b0;
      if (rep_active) begin
         rep_phase_d = rep_phase_q;
         if (rep_cnt_q == RP_MAX) begin
            rep_cnt_d = '0;
            if (rep_phase_q == 2'd3) begin
               rep_fire = 1'b1;
            end else begin
               rep_phase_d = rep_phase_q + 1'b1;
            end
         end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
         end
      end
   end

   // Repeat timer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt_q   <= '0;
         rep_phase_q <= '0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
      end
   end

   assign rep_up = rep_fire & db_vec[B_U];
   assign rep_dn = rep_fire & db_vec[B_D];
`else
   assign rep_up = 1'b0;
   assign rep_dn = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Mode select FSM
   // ------------------------------------------------------------------
   opr_mode_t mode_q, mode_d;
   logic      step_up;
   logic      step_dn;

   assign step_up = pulse_vec[B_U] | rep_up;
   assign step_dn = pulse_vec[B_D] | rep_dn;

   // L forces ADD; U/D wrap within 0..NUM_MODES-1; U with D cancels
   always_comb begin
      mode_d = mode_q;
      if (pulse_vec[B_L]) begin
         mode_d = MODE_ADD;
      end else if (step_up && !step_dn) begin
         mode_d = (mode_q == MODE_LAST) ? MODE_ADD : mode_q + 1'b1;
      end else if (step_dn && !step_up) begin
         mode_d = (mode_q == MODE_ADD) ? MODE_LAST : mode_q - 1'b1;
      end
   end

   // Mode state register
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= MODE_ADD;
      end else begin
         mode_q <= mode_d;
      end
   end

   // ------------------------------------------------------------------
   // Hold FSM and switch latch
   // ------------------------------------------------------------------
   hold_state_t     hold_q, hold_d;
   logic [BITS-1:0] sw_q, sw_d;

   // R releases (and wins over C); C toggles. SW follows the
   // synchronized switches whenever the next hold state is off, so
   // a freeze bites on the very edge HOLD rises.
   always_comb begin
      hold_d = hold_q;
      if (pulse_vec[B_R]) begin
         hold_d = HOLD_OFF;
      end else if (pulse_vec[B_C]) begin
         hold_d = (hold_q == HOLD_ON) ? HOLD_OFF : HOLD_ON;
      end
      sw_d = (hold_d == HOLD_OFF) ? sw_sync_q : sw_q;
   end

   // Hold state and switch word registers
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= HOLD_OFF;
         sw_q   <= '0;
      end else begin
         hold_q <= hold_d;
         sw_q   <= sw_d;
      end
   end

   assign SW        = sw_q;
   assign SELECTOR  = mode_q;
   assign HOLD      = (hold_q == HOLD_ON);
   assign BTN_PULSE = pulse_vec;

endmodule
